// File: rtl/divider_bus_master.sv
// Bus initiator that drives the divider coprocessor write-N/D, SYNC1, SYNC0, read-Q/R sequence.
// Optional poll timeout enabled by defining DIVM_POLL_TIMEOUT_EN.
module divider_bus_master #(
  parameter int DW       = 16,
  parameter int MAX_POLL = 255
) (
  input  logic          clk,
  input  logic          reset,
  output logic [2:0]    address,
  output logic          read,
  input  logic [31:0]   readdata,
  output logic          write,
  output logic [31:0]   writedata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_n,
  input  logic [DW-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_q,
  output logic [DW-1:0] out_r,
  output logic          out_err
);

  typedef enum logic [3:0] {
    IDLE, WR_N, WR_D, WR_CIN1, POLL1, WR_CIN0, POLL0, RD_Q, RD_R, RESP
  } state_t;

  localparam logic [2:0] A_N = 3'd0, A_D = 3'd1, A_CIN = 3'd2,
                         A_Q = 3'd3, A_R = 3'd4, A_COUT = 3'd5;

  state_t        state, state_n;
  logic [DW-1:0] n_q, d_q;
  logic          timeout;
  logic          abort;
  logic          unused_rd;

  assign unused_rd = ^readdata;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);

`ifdef DIVM_POLL_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_POLL + 1) > 8) ? $clog2(MAX_POLL + 1) : 8;
  logic [CW-1:0] cnt;
  logic          err;

  // Fires on the last permitted poll read that still sees no match.
  assign timeout = ((state == POLL1 && !readdata[0]) || (state == POLL0 && readdata[0]))
                   && (cnt == CW'(MAX_POLL - 1));
  assign abort   = err;
  assign out_err = err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) err <= 1'b0;
      else if (timeout)              err <= 1'b1;
      if (state_n != state) cnt <= '0;
      else if (state == POLL1 || state == POLL0) cnt <= cnt + 1'b1;
    end
  end
`else
  logic [7:0] unused_cfg;
  assign unused_cfg = 8'(MAX_POLL);
  assign timeout    = 1'b0;
  assign abort      = 1'b0;
  assign out_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    read      = 1'b0;
    write     = 1'b0;
    address   = 3'd0;
    writedata = 32'd0;
    case (state)
      IDLE:    if (in_valid) state_n = WR_N;
      WR_N:    begin write = 1'b1; address = A_N; writedata = 32'(n_q); state_n = WR_D; end
      WR_D:    begin write = 1'b1; address = A_D; writedata = 32'(d_q); state_n = WR_CIN1; end
      WR_CIN1: begin write = 1'b1; address = A_CIN; writedata = 32'd1; state_n = POLL1; end
      POLL1: begin
        read = 1'b1; address = A_COUT;
        if (readdata[0] || timeout) state_n = WR_CIN0;
      end
      // After a SYNC1 timeout this write is the cleanup that drops Cin before reporting.
      WR_CIN0: begin
        write = 1'b1; address = A_CIN; writedata = 32'd0;
        state_n = abort ? RESP : POLL0;
      end
      POLL0: begin
        read = 1'b1; address = A_COUT;
        if (!readdata[0])  state_n = RD_Q;
        else if (timeout)  state_n = RESP;
      end
      RD_Q:    begin read = 1'b1; address = A_Q; state_n = RD_R; end
      RD_R:    begin read = 1'b1; address = A_R; state_n = RESP; end
      RESP:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q   <= '0;
      d_q   <= '0;
      out_q <= '0;
      out_r <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        n_q <= in_n;
        d_q <= in_d;
      end
      if (timeout) begin
        out_q <= '0;
        out_r <= '0;
      end else if (state == RD_Q) out_q <= readdata[DW-1:0];
      else if (state == RD_R)     out_r <= readdata[DW-1:0];
    end
  end

endmodule
